// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute control sequencer that drives the shared 16-bit bus strobes.
// Latency: strobes are a combinational decode of the current step; the datapath acts on them at the edge ending that step.
// Backpressure: Enable=0 freezes the step counter and forces all strobes low; HALT is left only through Rst.
module fetch_sequencer #(
  parameter bit HALT_ON_UNDEFINED = 1'b0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Enable,
  input  logic [15:0] Ir,
  input  logic        ZeroFlag,
  input  logic        CarryFlag,
  output logic        ProgramCounterOut,
  output logic        CountEnable,
  output logic        Jump,
  output logic        MarLoad,
  output logic        RamOut,
  output logic        RamWrite,
  output logic        IrLoad,
  output logic        IrOut,
  output logic        AccLoad,
  output logic        AccOut,
  output logic        BLoad,
  output logic        AluOut,
  output logic        AluSub,
  output logic        FlagsLoad,
  output logic        Halted
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  step_t      step_q, step_d;
  logic       halt_q, halt_d;
  logic [3:0] opcode;
  logic       op_defined;
  logic       op_halts;
  logic       op_two_cycle;

  assign opcode     = Ir[15:12];
  assign op_defined = (opcode <= OP_JC) || (opcode == OP_HLT);
  // Undefined opcodes either behave as HLT or as NOP, selected at build time.
  assign op_halts     = (opcode == OP_HLT) || (!op_defined && HALT_ON_UNDEFINED);
  assign op_two_cycle = (opcode == OP_NOP) || (!op_defined && !HALT_ON_UNDEFINED);

  // Step counter and halt flag, asynchronously cleared to T0 / running.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      step_q <= T0;
      halt_q <= 1'b0;
    end else begin
      step_q <= step_d;
      halt_q <= halt_d;
    end
  end

  // Next-step selection and strobe decode for the current step.
  always_comb begin
    step_d            = step_q;
    halt_d            = halt_q;
    ProgramCounterOut = 1'b0;
    CountEnable       = 1'b0;
    Jump              = 1'b0;
    MarLoad           = 1'b0;
    RamOut            = 1'b0;
    RamWrite          = 1'b0;
    IrLoad            = 1'b0;
    IrOut             = 1'b0;
    AccLoad           = 1'b0;
    AccOut            = 1'b0;
    BLoad             = 1'b0;
    AluOut            = 1'b0;
    AluSub            = 1'b0;
    FlagsLoad         = 1'b0;
    Halted            = halt_q && !Rst;

    if (Rst) begin
      // Outputs stay quiet while reset is asserted; the flops clear asynchronously.
      step_d = T0;
      halt_d = 1'b0;
    end else if (halt_q) begin
      step_d = T0;
    end else if (Enable) begin
      case (step_q)
        T0: begin
          ProgramCounterOut = 1'b1;
          MarLoad           = 1'b1;
          step_d            = T1;
        end
        T1: begin
          RamOut      = 1'b1;
          IrLoad      = 1'b1;
          CountEnable = 1'b1;
          // Only the next-step choice looks at Ir here, so a NOP finishes in two cycles.
          step_d      = op_two_cycle ? T0 : T2;
        end
        T2: begin
          step_d = T0;
          if (op_halts) begin
            halt_d = 1'b1;
          end else begin
            case (opcode)
              OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                IrOut   = 1'b1;
                MarLoad = 1'b1;
                step_d  = T3;
              end
              OP_LDI: begin
                IrOut   = 1'b1;
                AccLoad = 1'b1;
              end
              OP_JMP: begin
                IrOut = 1'b1;
                Jump  = 1'b1;
              end
              OP_JZ: begin
                IrOut = ZeroFlag;
                Jump  = ZeroFlag;
              end
              OP_JC: begin
                IrOut = CarryFlag;
                Jump  = CarryFlag;
              end
              default: ;
            endcase
          end
        end
        T3: begin
          step_d = T0;
          case (opcode)
            OP_LDA: begin
              RamOut  = 1'b1;
              AccLoad = 1'b1;
            end
            OP_STA: begin
              AccOut   = 1'b1;
              RamWrite = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              RamOut = 1'b1;
              BLoad  = 1'b1;
              step_d = T4;
            end
            default: ;
          endcase
        end
        T4: begin
          step_d = T0;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            AluOut    = 1'b1;
            AccLoad   = 1'b1;
            FlagsLoad = 1'b1;
            AluSub    = (opcode == OP_SUB);
          end
        end
        default: step_d = T0;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one instance per HALT_ON_UNDEFINED setting.
// Each step sets inputs shortly after a rising edge and checks the decoded strobes before the next one.
// Bus-exclusivity and Jump/CountEnable invariants are checked on every falling edge.
module tb_fetch_sequencer;

  logic        Clk;
  logic        Rst;
  logic        Enable;
  logic [15:0] Ir;
  logic        ZeroFlag;
  logic        CarryFlag;

  logic pc0, ce0, jmp0, mar0, ro0, rw0, irl0, iro0, acl0, aco0, bl0, alo0, sub0, fl0, hlt0;
  logic pc1, ce1, jmp1, mar1, ro1, rw1, irl1, iro1, acl1, aco1, bl1, alo1, sub1, fl1, hlt1;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [14:0] S_PC  = 15'h0001;
  localparam logic [14:0] S_CE  = 15'h0002;
  localparam logic [14:0] S_JMP = 15'h0004;
  localparam logic [14:0] S_MAR = 15'h0008;
  localparam logic [14:0] S_RO  = 15'h0010;
  localparam logic [14:0] S_RW  = 15'h0020;
  localparam logic [14:0] S_IRL = 15'h0040;
  localparam logic [14:0] S_IRO = 15'h0080;
  localparam logic [14:0] S_ACL = 15'h0100;
  localparam logic [14:0] S_ACO = 15'h0200;
  localparam logic [14:0] S_BL  = 15'h0400;
  localparam logic [14:0] S_ALO = 15'h0800;
  localparam logic [14:0] S_SUB = 15'h1000;
  localparam logic [14:0] S_FL  = 15'h2000;
  localparam logic [14:0] S_HLT = 15'h4000;
  localparam logic [14:0] NONE  = 15'h0000;
  localparam logic [14:0] F0    = S_PC | S_MAR;
  localparam logic [14:0] F1    = S_RO | S_IRL | S_CE;

  logic [14:0] obs0, obs1;
  assign obs0 = {hlt0, fl0, sub0, alo0, bl0, aco0, acl0, iro0, irl0, rw0, ro0, mar0, jmp0, ce0, pc0};
  assign obs1 = {hlt1, fl1, sub1, alo1, bl1, aco1, acl1, iro1, irl1, rw1, ro1, mar1, jmp1, ce1, pc1};

  fetch_sequencer #(.HALT_ON_UNDEFINED(1'b0)) dut0 (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Ir(Ir), .ZeroFlag(ZeroFlag), .CarryFlag(CarryFlag),
    .ProgramCounterOut(pc0), .CountEnable(ce0), .Jump(jmp0), .MarLoad(mar0), .RamOut(ro0),
    .RamWrite(rw0), .IrLoad(irl0), .IrOut(iro0), .AccLoad(acl0), .AccOut(aco0), .BLoad(bl0),
    .AluOut(alo0), .AluSub(sub0), .FlagsLoad(fl0), .Halted(hlt0)
  );

  fetch_sequencer #(.HALT_ON_UNDEFINED(1'b1)) dut1 (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Ir(Ir), .ZeroFlag(ZeroFlag), .CarryFlag(CarryFlag),
    .ProgramCounterOut(pc1), .CountEnable(ce1), .Jump(jmp1), .MarLoad(mar1), .RamOut(ro1),
    .RamWrite(rw1), .IrLoad(irl1), .IrOut(iro1), .AccLoad(acl1), .AccOut(aco1), .BLoad(bl1),
    .AluOut(alo1), .AluSub(sub1), .FlagsLoad(fl1), .Halted(hlt1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Invariants on every cycle, both instances.
  always @(negedge Clk) begin
    n_assert = n_assert + 4;
    assert (int'(pc0) + int'(ro0) + int'(iro0) + int'(aco0) + int'(alo0) <= 1)
      else begin n_fail++; $error("FAIL bus_excl0: observed %h expected at most one driver", obs0); end
    assert (!(jmp0 && ce0))
      else begin n_fail++; $error("FAIL jmp_ce0: observed %h expected Jump and CountEnable not both", obs0); end
    assert (int'(pc1) + int'(ro1) + int'(iro1) + int'(aco1) + int'(alo1) <= 1)
      else begin n_fail++; $error("FAIL bus_excl1: observed %h expected at most one driver", obs1); end
    assert (!(jmp1 && ce1))
      else begin n_fail++; $error("FAIL jmp_ce1: observed %h expected Jump and CountEnable not both", obs1); end
  end

  // Check the current cycle on both instances, then advance to just after the next rising edge.
  task automatic chk2(input string tag, input logic [14:0] exp0, input logic [14:0] exp1);
    #1;
    n_assert = n_assert + 2;
    assert (obs0 === exp0)
      else begin n_fail++; $error("FAIL %s (HOU=0): observed %h expected %h", tag, obs0, exp0); end
    assert (obs1 === exp1)
      else begin n_fail++; $error("FAIL %s (HOU=1): observed %h expected %h", tag, obs1, exp1); end
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [14:0] exp);
    chk2(tag, exp, exp);
  endtask

  initial begin
    Rst = 1'b1; Enable = 1'b1; Ir = 16'h0000; ZeroFlag = 1'b0; CarryFlag = 1'b0;
    @(posedge Clk); #1;
    chk("reset_a", NONE);
    chk("reset_b", NONE);
    Rst = 1'b0;

    // LDI: three cycles, then straight into ADD's T0.
    Ir = 16'h5042;
    chk("ldi_t0", F0);
    chk("ldi_t1", F1);
    chk("ldi_t2", S_IRO | S_ACL);
    Ir = 16'h3010;
    chk("add_t0", F0);
    chk("add_t1", F1);
    chk("add_t2", S_IRO | S_MAR);
    chk("add_t3", S_RO | S_BL);
    chk("add_t4", S_ALO | S_ACL | S_FL);
    Ir = 16'h4011;
    chk("sub_t0", F0);
    chk("sub_t1", F1);
    chk("sub_t2", S_IRO | S_MAR);
    chk("sub_t3", S_RO | S_BL);
    chk("sub_t4", S_ALO | S_ACL | S_FL | S_SUB);
    Ir = 16'h1005;
    chk("lda_t0", F0);
    chk("lda_t1", F1);
    chk("lda_t2", S_IRO | S_MAR);
    chk("lda_t3", S_RO | S_ACL);

    // Conditional and unconditional jumps.
    Ir = 16'h7020; ZeroFlag = 1'b0; CarryFlag = 1'b1;
    chk("jz0_t0", F0);
    chk("jz0_t1", F1);
    chk("jz0_t2", NONE);
    ZeroFlag = 1'b1; CarryFlag = 1'b0;
    chk("jz1_t0", F0);
    chk("jz1_t1", F1);
    chk("jz1_t2", S_IRO | S_JMP);
    Ir = 16'h8020; ZeroFlag = 1'b1; CarryFlag = 1'b0;
    chk("jc0_t0", F0);
    chk("jc0_t1", F1);
    chk("jc0_t2", NONE);
    ZeroFlag = 1'b0; CarryFlag = 1'b1;
    chk("jc1_t0", F0);
    chk("jc1_t1", F1);
    chk("jc1_t2", S_IRO | S_JMP);
    Ir = 16'h6030; CarryFlag = 1'b0;
    chk("jmp_t0", F0);
    chk("jmp_t1", F1);
    chk("jmp_t2", S_IRO | S_JMP);

    // STA with Enable low for three cycles at T2.
    Ir = 16'h2007;
    chk("sta_t0", F0);
    chk("sta_t1", F1);
    Enable = 1'b0;
    chk("sta_hold0", NONE);
    chk("sta_hold1", NONE);
    chk("sta_hold2", NONE);
    Enable = 1'b1;
    chk("sta_t2", S_IRO | S_MAR);
    chk("sta_t3", S_ACO | S_RW);

    // Reset in the middle of ADD at T3.
    Ir = 16'h3010;
    chk("add2_t0", F0);
    chk("add2_t1", F1);
    chk("add2_t2", S_IRO | S_MAR);
    Rst = 1'b1;
    chk("rst_mid_a", NONE);
    chk("rst_mid_b", NONE);
    Rst = 1'b0;
    chk("rst_rel_t0", F0);
    chk("add3_t1", F1);
    chk("add3_t2", S_IRO | S_MAR);
    chk("add3_t3", S_RO | S_BL);
    chk("add3_t4", S_ALO | S_ACL | S_FL);

    // Undefined opcode: NOP on one instance, halt on the other.
    Ir = 16'hA000;
    chk("undef_t0", F0);
    chk("undef_t1", F1);
    chk2("undef_c2", F0, NONE);
    chk2("undef_c3", F1, S_HLT);
    Rst = 1'b1;
    chk("undef_rst", NONE);
    Rst = 1'b0;

    // HLT: sticky until reset, regardless of Enable or Ir.
    Ir = 16'hF000;
    chk("hlt_t0", F0);
    chk("hlt_t1", F1);
    chk("hlt_t2", NONE);
    for (int i = 0; i < 20; i++) begin
      Ir = (i % 2 == 0) ? 16'h5042 : 16'hF000;
      chk("hlt_hold", S_HLT);
    end
    Enable = 1'b0;
    chk("hlt_en0", S_HLT);
    Enable = 1'b1;
    Rst = 1'b1;
    chk("hlt_rst", NONE);
    Rst = 1'b0;
    Ir = 16'h0000;
    chk("after_hlt_t0", F0);
    chk("nop_t1", F1);
    chk("nop_next_t0", F0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
